arith_monitor: RTL

- Checker stage directly downstream of the stimulus driver in the arithmetic testbench.
- Consumes the driver's delayed monitor operands, the DUT result and the measured DUT delay.
- Computes the golden result and aligns it to the DUT output through a history line tapped by the measured delay.
- Compares every cycle, keeps test/error counters and captures the first failing vector for readout.

---
 rtl/arith_monitor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/arith_monitor.sv
// Result checker: golden model aligned to the DUT output via a delay-tapped history line,
// with saturating test/error counters and first-failure capture.
module arith_monitor #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned OP      = 0,
   parameter int unsigned MON_LAG = 2,
   parameter int unsigned DEPTH   = 16
) (
   input  logic             clk_dut,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_mon_a,
   input  logic [WIDTH-1:0] i_mon_b,
   input  logic [WIDTH-1:0] i_dut_out,
   input  logic [31:0]      i_dut_delay,
   input  logic             i_clear,
   output logic [3:0]       o_state,
   output logic [31:0]      o_test_count,
   output logic [31:0]      o_err_count,
   output logic [WIDTH-1:0] o_first_exp,
   output logic [WIDTH-1:0] o_first_got,
   output logic [31:0]      o_first_idx,
   output logic             o_pass
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [3:0] {
      S_WAIT = 4'b0001,
      S_FILL = 4'b0010,
      S_RUN  = 4'b0100,
      S_BAD  = 4'b1000
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  hist_q [DEPTH];
   logic [WIDTH-1:0]  hist_d [DEPTH];
   logic [31:0]       dly_q, dly_d;
   logic [CW-1:0]     fill_q, fill_d;
   logic [31:0]       test_cnt_q, test_cnt_d;
   logic [31:0]       err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]  first_exp_q, first_exp_d;
   logic [WIDTH-1:0]  first_got_q, first_got_d;
   logic [31:0]       first_idx_q, first_idx_d;

   logic [WIDTH-1:0]  f_now;
   logic [WIDTH-1:0]  exp_val;
   logic signed [32:0] align_in, align_run;
   logic              in_range, mismatch, delay_valid, soft_rst;

   function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      case (OP)
         1:       golden = a - b;
         2:       golden = a * b;
         default: golden = a + b;
      endcase
   endfunction

   // 33-bit signed so that D < MON_LAG shows up as a negative alignment
   function automatic logic signed [32:0] align_of(input logic [31:0] d);
      align_of = $signed({1'b0, d}) - $signed(33'(MON_LAG));
   endfunction

   always_comb begin
      f_now       = golden(i_mon_a, i_mon_b);
      align_in    = align_of(i_dut_delay);
      align_run   = align_of(dly_q);
      in_range    = (align_in >= 33'sd0) && (align_in <= $signed(33'(DEPTH)));
      delay_valid = (i_dut_delay != '1);
      soft_rst    = reset || i_clear;

      hist_d[0] = f_now;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         hist_d[k] = hist_q[k-1];
      end

      exp_val = f_now;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (align_run == $signed(33'(k + 1))) begin
            exp_val = hist_q[k];
         end
      end
      mismatch = (exp_val != i_dut_out);
   end

   // next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT:       if (delay_valid) state_d = in_range ? S_FILL : S_BAD;
         S_FILL:       if (fill_q == '0) state_d = S_RUN;
         S_RUN, S_BAD: state_d = state_q;
         default:      state_d = S_WAIT;
      endcase
      if (soft_rst) state_d = S_WAIT;
   end

   always_comb begin
      dly_d       = dly_q;
      fill_d      = fill_q;
      test_cnt_d  = test_cnt_q;
      err_cnt_d   = err_cnt_q;
      first_exp_d = first_exp_q;
      first_got_d = first_got_q;
      first_idx_d = first_idx_q;

      if (state_q == S_WAIT && delay_valid) begin
         dly_d = i_dut_delay;
         if (in_range) fill_d = align_in[CW-1:0];
      end
      if (state_q == S_FILL && fill_q != '0) begin
         fill_d = fill_q - 1'b1;
      end
      if (state_q == S_RUN) begin
         if (test_cnt_q != '1) test_cnt_d = test_cnt_q + 32'd1;
         if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
            if (err_cnt_q == '0) begin
               first_exp_d = exp_val;
               first_got_d = i_dut_out;
               first_idx_d = test_cnt_q;
            end
         end
      end

      if (soft_rst) begin
         dly_d       = '0;
         fill_d      = '0;
         test_cnt_d  = '0;
         err_cnt_d   = '0;
         first_exp_d = '0;
         first_got_d = '0;
         first_idx_d = '0;
      end
   end

   always_ff @(posedge clk_dut) begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      dly_q       <= dly_d;
      fill_q      <= fill_d;
      test_cnt_q  <= test_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      first_idx_q <= first_idx_d;
   end

   // outputs
   always_comb begin
      o_state      = state_q;
      o_test_count = test_cnt_q;
      o_err_count  = err_cnt_q;
      o_first_exp  = first_exp_q;
      o_first_got  = first_got_q;
      o_first_idx  = first_idx_q;
      o_pass       = (state_q == S_RUN) && (err_cnt_q == '0);
   end

endmodule
